// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared types and constants for the memcopy engine slice.
//            Holds the copy FSM state encoding and the memcopy opcode.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Copy engine FSM states
  typedef enum logic [2:0] {
    CP_IDLE  = 3'd0,
    CP_READ  = 3'd1,
    CP_WRITE = 3'd2,
    CP_DONE  = 3'd3
  } copy_state_t;

  // Custom-0 opcode slot used by the memcopy instruction
  localparam logic [6:0] OPC_MEMCOPY = 7'b0001011;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/copy_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : copy_addr_gen
// Purpose  : Address generator for the memcopy engine. Latches the source and
//            destination bases and the length on load, chooses the copy
//            direction, and walks the word index one step per write.
// Ports    : clk, reset (async active-low)
//            load        - latch bases/length, initialise index
//            step        - advance index (ignored on the last word)
//            from/to/len - request fields sampled on load
//            src_addr    - from + idx (wraps at DM_ADDRESS bits)
//            dst_addr    - to + idx   (wraps at DM_ADDRESS bits)
//            last        - current index is the final word
// Revision : 1.0 - initial release
// ============================================================================
module copy_addr_gen #(
  parameter int DM_ADDRESS = 9,
  parameter int COPY_W     = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [DM_ADDRESS-1:0] from,
  input  logic [DM_ADDRESS-1:0] to,
  input  logic [COPY_W-1:0]     len,
  output logic [DM_ADDRESS-1:0] src_addr,
  output logic [DM_ADDRESS-1:0] dst_addr,
  output logic                  last
);

  logic [DM_ADDRESS-1:0] r_from;
  logic [DM_ADDRESS-1:0] r_to;
  logic [COPY_W-1:0]     r_len;
  logic [COPY_W-1:0]     r_idx;
  logic                  r_dir_down;
  logic                  w_dir_down;
  logic [DM_ADDRESS-1:0] w_idx_ext;

  // Copying downwards when the destination lies above the source keeps
  // overlapping regions intact (memmove semantics). Only start addresses count.
  assign w_dir_down = (to > from);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_from     <= '0;
      r_to       <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_dir_down <= 1'b0;
    end else if (load) begin
      r_from     <= from;
      r_to       <= to;
      r_len      <= len;
      r_dir_down <= w_dir_down;
      // A zero length never reaches READ, so the len-1 underflow is harmless.
      r_idx      <= w_dir_down ? (len - COPY_W'(1)) : '0;
    end else if (step && !last) begin
      r_idx <= r_dir_down ? (r_idx - COPY_W'(1)) : (r_idx + COPY_W'(1));
    end
  end

  assign last      = r_dir_down ? (r_idx == '0) : (r_idx == (r_len - COPY_W'(1)));
  assign w_idx_ext = DM_ADDRESS'(r_idx);
  assign src_addr  = r_from + w_idx_ext;
  assign dst_addr  = r_to + w_idx_ext;

endmodule : copy_addr_gen
`default_nettype wire

// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
// Module   : mem_copy_engine
// Purpose  : Multi-cycle memcopy responder. Copies copy_len words from
//            copy_from to copy_to, one word every two cycles (read, then
//            write with the returned data), and stalls the PC until done.
// Ports    : clk, reset (async active-low)
//            req_valid, copy_from, copy_to, copy_len - request from decode
//            req_ready, busy, done, stall            - handshake / status
//            mem_re, mem_we, mem_addr, mem_wdata     - data-memory port
//            mem_rdata                               - read data (1-cycle)
// Revision : 1.0 - initial release
// ============================================================================
module mem_copy_engine
  import riscv_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int COPY_W     = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [DM_ADDRESS-1:0] copy_from,
  input  logic [DM_ADDRESS-1:0] copy_to,
  input  logic [COPY_W-1:0]     copy_len,
  output logic                  req_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  stall,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  copy_state_t           r_state;
  copy_state_t           w_state_nxt;
  logic                  w_load;
  logic                  w_step;
  logic                  w_last;
  logic [DM_ADDRESS-1:0] w_src_addr;
  logic [DM_ADDRESS-1:0] w_dst_addr;

  assign w_load = (r_state == CP_IDLE) && req_valid;
  assign w_step = (r_state == CP_WRITE);

  copy_addr_gen #(
    .DM_ADDRESS (DM_ADDRESS),
    .COPY_W     (COPY_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .step     (w_step),
    .from     (copy_from),
    .to       (copy_to),
    .len      (copy_len),
    .src_addr (w_src_addr),
    .dst_addr (w_dst_addr),
    .last     (w_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= CP_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      CP_IDLE:  if (req_valid) w_state_nxt = (copy_len == '0) ? CP_DONE : CP_READ;
      CP_READ:  w_state_nxt = CP_WRITE;
      CP_WRITE: w_state_nxt = w_last ? CP_DONE : CP_READ;
      CP_DONE:  w_state_nxt = CP_IDLE;
      default:  w_state_nxt = CP_IDLE;
    endcase
  end

  // Output decode is purely from state, so an async reset clears every
  // output in the same instant the state returns to IDLE.
  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (r_state)
      CP_READ: begin
        mem_re   = 1'b1;
        mem_addr = w_src_addr;
      end
      CP_WRITE: begin
        // Read data from the previous cycle flows straight to the write port.
        mem_we    = 1'b1;
        mem_addr  = w_dst_addr;
        mem_wdata = mem_rdata;
      end
      default: begin
        mem_re = 1'b0;
      end
    endcase
  end

  assign done      = (r_state == CP_DONE);
  assign busy      = (r_state != CP_IDLE);
  assign req_ready = (r_state == CP_IDLE);
  // The PC advances on the edge that leaves DONE, so the stall drops there.
  assign stall     = req_valid && !done;

endmodule : mem_copy_engine
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_copy_engine
// Purpose  : Self-checking bench for mem_copy_engine. A behavioural memory
//            model answers the engine's port; expected reads, writes and done
//            timing are queued on request issue and popped by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_copy_engine;

  localparam int DMA = 9;
  localparam int DW  = 32;
  localparam int CW  = 7;
  localparam int MSZ = 1 << DMA;

  logic           clk;
  logic           reset;
  logic           req_valid;
  logic [DMA-1:0] copy_from;
  logic [DMA-1:0] copy_to;
  logic [CW-1:0]  copy_len;
  logic           req_ready;
  logic           busy;
  logic           done;
  logic           stall;
  logic           mem_re;
  logic           mem_we;
  logic [DMA-1:0] mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata;

  mem_copy_engine #(.DM_ADDRESS(DMA), .DATA_W(DW), .COPY_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .copy_from (copy_from),
    .copy_to   (copy_to),
    .copy_len  (copy_len),
    .req_ready (req_ready),
    .busy      (busy),
    .done      (done),
    .stall     (stall),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] mem  [MSZ];   // memory seen by the DUT
  logic [DW-1:0] refm [MSZ];   // reference model's view of memory
  logic [DW-1:0] rdata_q;

  logic [DMA-1:0]      rq[$];  // expected read addresses
  logic [DMA+DW-1:0]   wq[$];  // expected {addr, data} writes
  int                  dq[$];  // expected cycle of done

  assign mem_rdata = rdata_q;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) rdata_q <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents memory traffic or done.
  always @(negedge clk) begin
    if (reset) begin
      if (mem_re || mem_we) check("re_we_exclusive", 64'(mem_re & mem_we), 64'd0);
      if (mem_re) begin
        if (rq.size() == 0) check("unexpected_read", 64'(mem_addr), 64'h1_0000_0000);
        else check("read_addr", 64'(mem_addr), 64'(rq.pop_front()));
      end
      if (mem_we) begin
        if (wq.size() == 0) check("unexpected_write", 64'(mem_addr), 64'h1_0000_0000);
        else check("write_addr_data", 64'({mem_addr, mem_wdata}), 64'(wq.pop_front()));
      end
      if (done) begin
        if (dq.size() == 0) check("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
        else check("done_cycle", 64'(cyc), 64'(dq.pop_front()));
      end
    end
  end

  // Reference model: memmove of l words; direction from start addresses,
  // addresses wrap modulo memory size. nr/nw bound how much of the copy
  // happens (used when a reset aborts mid-copy).
  task automatic model(input int f, input int t, input int l, input int nr, input int nw);
    bit down;
    int i;
    logic [DMA-1:0] sa, da;
    down = (t % MSZ) > (f % MSZ);
    for (int k = 0; k < l; k++) begin
      i  = down ? (l - 1 - k) : k;
      sa = DMA'((f + i) % MSZ);
      da = DMA'((t + i) % MSZ);
      if (k < nr) rq.push_back(sa);
      if (k < nw) begin
        wq.push_back({da, refm[sa]});
        refm[da] = refm[sa];
      end
    end
  endtask

  task automatic compare_mem(input string name);
    int diffs = 0;
    for (int a = 0; a < MSZ; a++) if (mem[a] !== refm[a]) diffs++;
    check(name, 64'(diffs), 64'd0);
  endtask

  // Issue one request, hold it until done, then drop it (PC advances).
  task automatic do_copy(input int f, input int t, input int l, input string name);
    bit got = 0;
    copy_from = DMA'(f);
    copy_to   = DMA'(t);
    copy_len  = CW'(l);
    req_valid = 1'b1;
    model(f, t, l, l, l);
    dq.push_back(cyc + 2 * l + 1);
    #1 check("stall_at_accept", 64'(stall), 64'd1);
    for (int n = 0; n < 2 * l + 10; n++) begin
      @(negedge clk);
      if (done) begin
        check("stall_release", 64'(stall), 64'd0);
        got = 1;
        break;
      end
      if (stall !== 1'b1) check("stall_held", 64'(stall), 64'd1);
      // Scramble inputs after acceptance; the engine must use latched values.
      copy_from = DMA'($urandom);
      copy_to   = DMA'($urandom);
      copy_len  = CW'($urandom);
    end
    req_valid = 1'b0;
    if (!got) check({name, "_timeout"}, 64'd0, 64'd1);
    compare_mem({name, "_mem"});
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    copy_from = '0;
    copy_to   = '0;
    copy_len  = '0;
    for (int a = 0; a < MSZ; a++) begin
      mem[a]  = $urandom;
      refm[a] = mem[a];
    end
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_re_we", 64'({mem_re, mem_we}), 64'd0);
    check("rst_addr_wdata", 64'({mem_addr, mem_wdata}), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);

    // 1: basic ascending copy, done at cycle 9
    for (int k = 0; k < 4; k++) begin
      mem[10 + k]  = 32'hA + k;
      refm[10 + k] = 32'hA + k;
    end
    do_copy(10, 40, 4, "t1");
    // 2: zero length, done at cycle 1 with no memory traffic
    @(negedge clk);
    do_copy(77, 300, 0, "t2_len0");
    // 3: overlapping, destination above source
    for (int k = 0; k < 4; k++) begin
      mem[20 + k]  = k + 1;
      refm[20 + k] = k + 1;
    end
    @(negedge clk);
    do_copy(20, 22, 4, "t3_down");
    check("t3_word", 64'(mem[25]), 64'd4);
    // 4: overlapping, destination below source
    @(negedge clk);
    do_copy(22, 20, 4, "t4_up");
    // 5: source wraps past the top of memory
    @(negedge clk);
    do_copy(510, 100, 4, "t5_wrap");

    // 6: reset asserted during cycle 3 of a len=8 copy
    @(negedge clk);
    copy_from = DMA'(200);
    copy_to   = DMA'(300);
    copy_len  = CW'(8);
    req_valid = 1'b1;
    model(200, 300, 8, 2, 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_re_we_done", 64'({mem_re, mem_we, done}), 64'd0);
    check("abort_addr", 64'(mem_addr), 64'd0);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready", 64'(req_ready), 64'd1);
    check("abort_queues", 64'(rq.size() + wq.size()), 64'd0);
    compare_mem("t6_mem");
    do_copy(50, 60, 2, "t6_after");

    // Random copies, including wrap and overlap
    for (int r = 0; r < 12; r++) begin
      @(negedge clk);
      do_copy($urandom_range(0, MSZ - 1), $urandom_range(0, MSZ - 1),
              $urandom_range(0, 24), "rand");
    end

    repeat (3) @(negedge clk);
    check("queues_drained", 64'(rq.size() + wq.size() + dq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_copy_engine
`default_nettype wire
